// File: rtl/count_checker.sv
// Monitors an upstream modulo-2^WIDTH up-counter: locks after SYNC_LEN good steps,
// counts wraps while locked, and raises a sticky err on any bad step. Optional macro: STALL_TOL_EN.
module count_checker #(
  parameter int WIDTH     = 4,
  parameter int WRAP_W    = 8,
  parameter int SYNC_LEN  = 2,
  parameter int MAX_STALL = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cnt_in,
  output logic              locked,
  output logic              err,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam int GOOD_W = $clog2(SYNC_LEN + 1);

  // Parameter sanity gate; an illegal setting leaves a visible marker block in the hierarchy.
  if (SYNC_LEN < 1 || MAX_STALL < 0) begin : g_illegal_params
  end

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic                wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;

  logic [WIDTH-1:0]    next_exp;
  logic [GOOD_W-1:0]   good_inc;
  logic                step_good;
  logic                step_wrap;

`ifdef STALL_TOL_EN
  // The stall counter saturates one past the limit so it can never roll back to "healthy".
  localparam int STALL_W = $clog2(MAX_STALL + 2);
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [STALL_W-1:0]  stall_inc;
  logic                is_stall;
  logic                stall_over;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    prev_d       = cnt_in;
    good_d       = good_q;
    err_d        = err_q;
    wrap_pulse_d = 1'b0;
    wrap_cnt_d   = wrap_cnt_q;

    next_exp  = prev_q + WIDTH'(1);
    good_inc  = good_q + GOOD_W'(1);
    step_good = (cnt_in == next_exp);
    step_wrap = (prev_q == '1) && (cnt_in == '0);

`ifdef STALL_TOL_EN
    stall_d    = stall_q;
    is_stall   = (cnt_in == prev_q);
    stall_inc  = (stall_q == STALL_W'(MAX_STALL + 1)) ? stall_q : stall_q + STALL_W'(1);
    stall_over = (stall_inc > STALL_W'(MAX_STALL));
`endif

    unique case (state_q)
      IDLE: begin
        state_d = SYNC;
        good_d  = '0;
`ifdef STALL_TOL_EN
        stall_d = '0;
`endif
      end

      SYNC: begin
`ifdef STALL_TOL_EN
        if (is_stall) begin
          stall_d = stall_inc;
          if (stall_over) good_d = '0;
        end else begin
          stall_d = '0;
`endif
          if (step_good) begin
            if (good_inc == GOOD_W'(SYNC_LEN)) begin
              state_d = TRACK;
              good_d  = '0;
            end else begin
              good_d  = good_inc;
            end
          end else begin
            good_d = '0;
          end
`ifdef STALL_TOL_EN
        end
`endif
      end

      TRACK: begin
`ifdef STALL_TOL_EN
        if (is_stall) begin
          stall_d = stall_inc;
          if (stall_over) begin
            state_d = FAULT;
            err_d   = 1'b1;
          end
        end else begin
          stall_d = '0;
`endif
          if (step_good) begin
            if (step_wrap) begin
              wrap_pulse_d = 1'b1;
              if (wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
            end
          end else begin
            state_d = FAULT;
            err_d   = 1'b1;
          end
`ifdef STALL_TOL_EN
        end
`endif
      end

      FAULT: begin
        err_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    locked_d = (state_d == TRACK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      good_q       <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
`ifdef STALL_TOL_EN
      stall_q      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_q       <= good_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
`ifdef STALL_TOL_EN
      stall_q      <= stall_d;
`endif
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;

endmodule

// File: tb/tb_count_checker.sv
// Scenario-driven bench for count_checker: each step pushes its expected outputs to a
// scoreboard and pops/compares them one time unit after the sampling edge.
module tb_count_checker;

  logic       clk;
  logic       rst;
  logic [3:0] cnt_in;
  logic       locked;
  logic       err;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       locked;
    logic       err;
    logic       pulse;
    logic [7:0] wcnt;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  count_checker #(
    .WIDTH    (4),
    .WRAP_W   (8),
    .SYNC_LEN (2),
    .MAX_STALL(3)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .locked    (locked),
    .err       (err),
    .wrap_pulse(wrap_pulse),
    .wrap_cnt  (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one count value, push its expectation, compare after the sampling edge.
  // Entered and left on a negedge.
  task automatic step(input logic [3:0] v, input logic el, input logic ee, input logic ep,
                      input logic [7:0] ew, input string tag);
    exp_t e;
    cnt_in   = v;
    e.locked = el;
    e.err    = ee;
    e.pulse  = ep;
    e.wcnt   = ew;
    e.tag    = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    n_checks++;
    if (locked !== e.locked) begin
      n_fail++;
      $display("FAIL %s locked: got %b expected %b", e.tag, locked, e.locked);
    end
    n_checks++;
    if (err !== e.err) begin
      n_fail++;
      $display("FAIL %s err: got %b expected %b", e.tag, err, e.err);
    end
    n_checks++;
    if (wrap_pulse !== e.pulse) begin
      n_fail++;
      $display("FAIL %s wrap_pulse: got %b expected %b", e.tag, wrap_pulse, e.pulse);
    end
    n_checks++;
    if (wrap_cnt !== e.wcnt) begin
      n_fail++;
      $display("FAIL %s wrap_cnt: got %0d expected %0d", e.tag, wrap_cnt, e.wcnt);
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({locked, err, wrap_pulse, wrap_cnt} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state: got l=%b e=%b p=%b w=%0d expected all zero",
               locked, err, wrap_pulse, wrap_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_lock();
    step(4'd0, 1'b0, 1'b0, 1'b0, 8'd0, "lock_idle");
    step(4'd1, 1'b0, 1'b0, 1'b0, 8'd0, "lock_sync1");
    step(4'd2, 1'b1, 1'b0, 1'b0, 8'd0, "lock_track");
  endtask

  // Continues from a locked state with prev=2.
  task automatic test_wrap();
    int exp_w;
    for (int v = 3; v <= 15; v++) step(4'(v), 1'b1, 1'b0, 1'b0, 8'd0, "wrap_ramp");
    step(4'd0, 1'b1, 1'b0, 1'b1, 8'd1, "wrap_first");
    step(4'd1, 1'b1, 1'b0, 1'b0, 8'd1, "wrap_after");
    exp_w = 1;
    for (int w = 0; w < 300; w++) begin
      for (int v = 2; v <= 15; v++) step(4'(v), 1'b1, 1'b0, 1'b0, 8'(exp_w), "wrap_run");
      if (exp_w < 255) exp_w++;
      step(4'd0, 1'b1, 1'b0, 1'b1, 8'(exp_w), "wrap_hit");
      step(4'd1, 1'b1, 1'b0, 1'b0, 8'(exp_w), "wrap_post");
    end
    step(4'd2, 1'b1, 1'b0, 1'b0, 8'd255, "wrap_saturated");
  endtask

  task automatic test_fault();
    reset_dut();
    step(4'd13, 1'b0, 1'b0, 1'b0, 8'd0, "fault_idle");
    step(4'd14, 1'b0, 1'b0, 1'b0, 8'd0, "fault_sync");
    step(4'd15, 1'b1, 1'b0, 1'b0, 8'd0, "fault_lock");
    step(4'd0,  1'b1, 1'b0, 1'b1, 8'd1, "fault_wrap");
    for (int v = 1; v <= 6; v++) step(4'(v), 1'b1, 1'b0, 1'b0, 8'd1, "fault_run");
    step(4'd9,  1'b0, 1'b1, 1'b0, 8'd1, "fault_jump");
    for (int v = 10; v <= 15; v++) step(4'(v), 1'b0, 1'b1, 1'b0, 8'd1, "fault_sticky");
    step(4'd0,  1'b0, 1'b1, 1'b0, 8'd1, "fault_no_wrap");
    step(4'd1,  1'b0, 1'b1, 1'b0, 8'd1, "fault_frozen");
  endtask

  task automatic test_resync();
    reset_dut();
    step(4'd3, 1'b0, 1'b0, 1'b0, 8'd0, "resync_idle");
    step(4'd4, 1'b0, 1'b0, 1'b0, 8'd0, "resync_good1");
    step(4'd7, 1'b0, 1'b0, 1'b0, 8'd0, "resync_bad");
    step(4'd8, 1'b0, 1'b0, 1'b0, 8'd0, "resync_restart");
    step(4'd9, 1'b1, 1'b0, 1'b0, 8'd0, "resync_lock");
  endtask

  // A bad step that lands on 0 must fault without a wrap pulse.
  task automatic test_fault_on_zero();
    reset_dut();
    step(4'd12, 1'b0, 1'b0, 1'b0, 8'd0, "zero_idle");
    step(4'd13, 1'b0, 1'b0, 1'b0, 8'd0, "zero_sync");
    step(4'd14, 1'b1, 1'b0, 1'b0, 8'd0, "zero_lock");
    step(4'd0,  1'b0, 1'b1, 1'b0, 8'd0, "zero_fault");
  endtask

  task automatic test_mid_reset();
    reset_dut();
    step(4'd0, 1'b0, 1'b0, 1'b0, 8'd0, "mid_idle");
    step(4'd1, 1'b0, 1'b0, 1'b0, 8'd0, "mid_sync");
    step(4'd2, 1'b1, 1'b0, 1'b0, 8'd0, "mid_lock");
    for (int w = 1; w <= 3; w++) begin
      for (int v = (w == 1) ? 3 : 1; v <= 15; v++)
        step(4'(v), 1'b1, 1'b0, 1'b0, 8'(w - 1), "mid_ramp");
      step(4'd0, 1'b1, 1'b0, 1'b1, 8'(w), "mid_wrap");
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({locked, err, wrap_pulse, wrap_cnt} !== 11'd0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got l=%b e=%b p=%b w=%0d expected all zero",
               locked, err, wrap_pulse, wrap_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    step(4'd0, 1'b0, 1'b0, 1'b0, 8'd0, "relock_idle");
    step(4'd1, 1'b0, 1'b0, 1'b0, 8'd0, "relock_sync");
    step(4'd2, 1'b1, 1'b0, 1'b0, 8'd0, "relock_track");
  endtask

  task automatic test_stall();
    reset_dut();
    step(4'd0, 1'b0, 1'b0, 1'b0, 8'd0, "stall_idle");
    step(4'd1, 1'b0, 1'b0, 1'b0, 8'd0, "stall_sync");
    step(4'd2, 1'b1, 1'b0, 1'b0, 8'd0, "stall_lock");
    step(4'd3, 1'b1, 1'b0, 1'b0, 8'd0, "stall_run");
    step(4'd4, 1'b1, 1'b0, 1'b0, 8'd0, "stall_run");
`ifdef STALL_TOL_EN
    for (int i = 0; i < 3; i++) step(4'd4, 1'b1, 1'b0, 1'b0, 8'd0, "stall_tolerated");
    step(4'd5, 1'b1, 1'b0, 1'b0, 8'd0, "stall_cleared");
    step(4'd6, 1'b1, 1'b0, 1'b0, 8'd0, "stall_run6");
    for (int i = 0; i < 3; i++) step(4'd6, 1'b1, 1'b0, 1'b0, 8'd0, "stall_hold6");
    step(4'd6, 1'b0, 1'b1, 1'b0, 8'd0, "stall_exceeded");
`else
    step(4'd4, 1'b0, 1'b1, 1'b0, 8'd0, "stall_is_bad");
    step(4'd5, 1'b0, 1'b1, 1'b0, 8'd0, "stall_sticky");
`endif
  endtask

  initial begin
    rst    = 1'b0;
    cnt_in = 4'd0;
    test_reset();
    test_lock();
    test_wrap();
    test_fault();
    test_resync();
    test_fault_on_zero();
    test_mid_reset();
    test_stall();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
